// File: rtl/llc_tag_dir.sv
// Set-associative LLC tag directory: per-way tag/valid/dirty, true-LRU ages, hit/miss counters.
// Latency: READ/WRITE/INVALIDATE respond 2 cycles after accept, CLEAR NUM_SETS+1, illegal cmd 1.
// Backpressure: cmd_ready is high only in IDLE; one command in flight, no queuing.
// Ports: clk/rst (sync, active-high); cmd_valid/cmd_ready/cmd/addr command handshake;
//        resp_* one-cycle registered response (fields zero when resp_valid is low);
//        hit_count/miss_count saturating READ/WRITE statistics.
module llc_tag_dir #(
  parameter int ADDR_W     = 32,
  parameter int NUM_SETS   = 4,
  parameter int WAYS       = 2,
  parameter int LINE_BYTES = 64,
  localparam int OFF_W = $clog2(LINE_BYTES),
  localparam int IDX_W = $clog2(NUM_SETS),
  localparam int WAY_W = $clog2(WAYS),
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd,
  input  logic [ADDR_W-1:0] addr,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [WAY_W-1:0]  resp_way,
  output logic              resp_evict,
  output logic              resp_wb,
  output logic [TAG_W-1:0]  resp_victim_tag,
  output logic              resp_err,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam logic [2:0] CMD_READ  = 3'd0;
  localparam logic [2:0] CMD_WRITE = 3'd1;
  localparam logic [2:0] CMD_INV   = 3'd2;
  localparam logic [2:0] CMD_CLEAR = 3'd3;

  typedef enum logic [2:0] {INIT, IDLE, LOOKUP, UPDATE, CLEAR} state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0] set_cnt;
  logic [2:0]       cmd_q;
  logic [IDX_W-1:0] idx_q;
  logic [TAG_W-1:0] tag_q;
  logic             lk_hit;
  logic [WAY_W-1:0] lk_way;

  logic [TAG_W-1:0] tag_mem   [NUM_SETS][WAYS];
  logic             valid_mem [NUM_SETS][WAYS];
  logic             dirty_mem [NUM_SETS][WAYS];
  logic [WAY_W-1:0] age_mem   [NUM_SETS][WAYS];

  logic             resp_valid_q, resp_hit_q, resp_evict_q, resp_wb_q, resp_err_q;
  logic [WAY_W-1:0] resp_way_q;
  logic [TAG_W-1:0] resp_vtag_q;

  logic             accept, walk_last;
  logic             hit, inv_found;
  logic [WAY_W-1:0] hit_way, inv_way, lru_way, victim, upd_age;

  // Line offset only selects bytes inside a line; the directory never needs it.
  logic unused_addr_off;
  assign unused_addr_off = ^addr[OFF_W-1:0];

  assign cmd_ready = (state == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign walk_last = (set_cnt == IDX_W'(NUM_SETS - 1));

  // Parallel tag compare plus victim choice: first invalid way, else the oldest (age WAYS-1).
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    victim    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_mem[idx_q][w] && (tag_mem[idx_q][w] == tag_q)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!inv_found && !valid_mem[idx_q][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
      if (age_mem[idx_q][w] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
    end
    victim  = inv_found ? inv_way : lru_way;
    upd_age = age_mem[idx_q][lk_way];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:   if (walk_last) state_nxt = IDLE;
      IDLE: begin
        if (accept) begin
          if (cmd <= CMD_INV)         state_nxt = LOOKUP;
          else if (cmd == CMD_CLEAR)  state_nxt = CLEAR;
        end
      end
      LOOKUP: state_nxt = UPDATE;
      UPDATE: state_nxt = IDLE;
      CLEAR:  if (walk_last) state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  // Control, response and counters. Response is registered at the end of LOOKUP so it
  // is visible during UPDATE; counters move on the same edge so they agree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      set_cnt      <= '0;
      cmd_q        <= '0;
      idx_q        <= '0;
      tag_q        <= '0;
      lk_hit       <= 1'b0;
      lk_way       <= '0;
      hit_count    <= '0;
      miss_count   <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_way_q   <= '0;
      resp_evict_q <= 1'b0;
      resp_wb_q    <= 1'b0;
      resp_vtag_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_way_q   <= '0;
      resp_evict_q <= 1'b0;
      resp_wb_q    <= 1'b0;
      resp_vtag_q  <= '0;
      resp_err_q   <= 1'b0;
      case (state)
        INIT: set_cnt <= set_cnt + IDX_W'(1);
        CLEAR: begin
          set_cnt <= set_cnt + IDX_W'(1);
          if (walk_last) resp_valid_q <= 1'b1;
        end
        IDLE: begin
          if (accept) begin
            cmd_q   <= cmd;
            idx_q   <= addr[OFF_W +: IDX_W];
            tag_q   <= addr[ADDR_W-1 -: TAG_W];
            set_cnt <= '0;
            if (cmd > CMD_CLEAR) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end
          end
        end
        LOOKUP: begin
          lk_hit       <= hit;
          lk_way       <= hit ? hit_way : victim;
          resp_valid_q <= 1'b1;
          resp_hit_q   <= hit;
          if (cmd_q == CMD_INV) begin
            if (hit) begin
              resp_way_q  <= hit_way;
              resp_wb_q   <= dirty_mem[idx_q][hit_way];
              resp_vtag_q <= tag_mem[idx_q][hit_way];
            end
          end else if (hit) begin
            resp_way_q <= hit_way;
            if (hit_count != '1) hit_count <= hit_count + 32'd1;
          end else begin
            resp_way_q   <= victim;
            resp_evict_q <= valid_mem[idx_q][victim];
            resp_wb_q    <= valid_mem[idx_q][victim] && dirty_mem[idx_q][victim];
            resp_vtag_q  <= valid_mem[idx_q][victim] ? tag_mem[idx_q][victim] : '0;
            if (miss_count != '1) miss_count <= miss_count + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Directory arrays. INIT/CLEAR wipe one set per cycle; reset needs no direct clear
  // because it always leads into the INIT walk.
  always_ff @(posedge clk) begin
    if (state == INIT || state == CLEAR) begin
      for (int w = 0; w < WAYS; w++) begin
        valid_mem[set_cnt][w] <= 1'b0;
        dirty_mem[set_cnt][w] <= 1'b0;
        tag_mem[set_cnt][w]   <= '0;
        age_mem[set_cnt][w]   <= WAY_W'(w);
      end
    end else if (state == UPDATE && !rst) begin
      if (cmd_q == CMD_INV) begin
        if (lk_hit) begin
          valid_mem[idx_q][lk_way] <= 1'b0;
          dirty_mem[idx_q][lk_way] <= 1'b0;
        end
      end else begin
        // Ways younger than the touched one age by one; touched way becomes MRU.
        for (int w = 0; w < WAYS; w++) begin
          if (age_mem[idx_q][w] < upd_age) age_mem[idx_q][w] <= age_mem[idx_q][w] + WAY_W'(1);
        end
        age_mem[idx_q][lk_way] <= '0;
        if (!lk_hit) begin
          valid_mem[idx_q][lk_way] <= 1'b1;
          tag_mem[idx_q][lk_way]   <= tag_q;
          dirty_mem[idx_q][lk_way] <= (cmd_q == CMD_WRITE);
        end else if (cmd_q == CMD_WRITE) begin
          dirty_mem[idx_q][lk_way] <= 1'b1;
        end
      end
    end
  end

  // Reset blanks the response in the same cycle so an aborted operation never reports.
  assign resp_valid      = resp_valid_q && !rst;
  assign resp_hit        = resp_hit_q && !rst;
  assign resp_way        = rst ? '0 : resp_way_q;
  assign resp_evict      = resp_evict_q && !rst;
  assign resp_wb         = resp_wb_q && !rst;
  assign resp_victim_tag = rst ? '0 : resp_vtag_q;
  assign resp_err        = resp_err_q && !rst;

endmodule

// File: doc/llc_tag_dir.md
Name: llc_tag_dir

Overview:
- Parametrised, clocked set-associative LLC tag directory.
- Adds the following over the earlier single-command tag lookup:
  - valid and dirty bits per way
  - true-LRU replacement
  - write, invalidate and clear commands
  - valid/ready command handshake and a registered response
  - hit/miss statistics
- Sits between the trace-driven command front end and the simulator's reporting and logging logic. No data array; tags and state only.

Parameters:
ADDR_W, 32, address width in bits
NUM_SETS, 4, number of sets (power of 2, >=2)
WAYS, 2, associativity (power of 2, >=2)
LINE_BYTES, 64, line size (power of 2)
Derived: OFF_W=log2(LINE_BYTES), IDX_W=log2(NUM_SETS), WAY_W=log2(WAYS), TAG_W=ADDR_W-IDX_W-OFF_W

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd  in  3  0=READ 1=WRITE 2=INVALIDATE 3=CLEAR, 4-7 illegal
addr  in  ADDR_W  byte address; offset=[OFF_W-1:0], index=[OFF_W+IDX_W-1:OFF_W], tag=upper TAG_W
resp_valid  out  1  one-cycle response pulse
resp_hit  out  1  tag matched a valid way
resp_way  out  WAY_W  way hit, allocated or invalidated
resp_evict  out  1  allocation replaced a valid line
resp_wb  out  1  replaced or invalidated line was dirty
resp_victim_tag  out  TAG_W  tag of replaced or invalidated line
resp_err  out  1  illegal command
hit_count  out  32  saturating READ/WRITE hit counter
miss_count  out  32  saturating READ/WRITE miss counter

Behaviour:
- States: INIT, IDLE, LOOKUP, UPDATE, CLEAR.
- rst:
  - Forces INIT and set counter 0; zeroes both counters.
  - All resp_* outputs go to 0; cmd_ready goes to 0.
  - rst during any state aborts that operation; no response is emitted for it.
- INIT/CLEAR walk: one set per cycle. In each set, valid, dirty and tag go to 0, and LRU ages are set so that way w has age w. This takes NUM_SETS cycles, then IDLE.
- cmd_ready=1 only in IDLE. Accept means cmd_valid && cmd_ready.
- On accept, cmd and addr are latched. Inputs are don't-care until the next accept.
- Accept of cmd 0-2 at cycle T:
  - LOOKUP at T+1 compares the tag against all ways in parallel.
  - UPDATE at T+2 writes state; resp_valid=1 during T+2; IDLE at T+3.
- CLEAR accepted at T: walk occupies T+1..T+NUM_SETS; resp_valid at T+NUM_SETS+1, with resp_hit=0 and the other resp fields 0.
- Illegal cmd: no state change; resp_valid and resp_err at T+1; back to IDLE.
- READ/WRITE hit on way h:
  - resp_hit=1, resp_way=h; hit_count+1.
  - WRITE sets dirty[h]; READ leaves dirty unchanged.
- READ/WRITE miss: victim is the lowest-index invalid way; if all ways are valid, the way with age WAYS-1.
  - Victim gets valid=1, tag=new tag, dirty=(cmd==WRITE).
  - resp_way=victim; resp_evict=victim was valid; resp_wb=victim was valid and dirty; resp_victim_tag=old tag (0 if invalid).
  - miss_count+1.
- LRU update on hit or allocation of way a with old age g:
  - every way with age < g increments;
  - age[a]=0;
  - other ages unchanged.
  - Ages stay a permutation of 0..WAYS-1.
- INVALIDATE:
  - On hit: clear valid and dirty; resp_hit=1; resp_way=h; resp_wb=old dirty; resp_victim_tag=tag.
  - On miss: resp_hit=0, no change.
  - LRU is not updated; counters are not changed.
- Counters saturate at 0xFFFF_FFFF and never wrap.
- Tag 0 with valid=1 is a legal resident line; matching always requires valid.
- resp fields are valid only while resp_valid=1 and are driven 0 otherwise.

Test Plan:
- Defaults. rst high for 1 cycle, then low -> cmd_ready=0 for 4 cycles, then 1.
  - READ 0x1000_0180 (idx 2, tag 0x100001) -> resp at T+2: hit=0, way=0, evict=0, miss_count=1.
  - Repeat -> hit=1, way=0, hit_count=1.
- Fill set 2:
  - READ 0x1000_0180, then READ 0x2000_0180 -> way 1.
  - READ 0x1000_0180 (hit, way 0 MRU).
  - READ 0x3000_0180 -> way=1, evict=1, wb=0, victim_tag=0x200001.
- Dirty eviction:
  - WRITE 0x1000_0180, then READ 0x2000_0180 -> way 1.
  - READ 0x3000_0180 -> victim way 0, wb=1, victim_tag=0x100001.
- INVALIDATE on a dirty resident line -> hit=1, wb=1. A following READ of the same address -> miss, way=same way.
- Illegal command and clear:
  - cmd=5 -> resp_err=1 at T+1, counters unchanged.
  - CLEAR -> cmd_ready=0 for 4 cycles, resp at T+5; every previous address then misses.
- Reset mid-operation:
  - rst asserted during UPDATE -> no resp_valid.
  - rst asserted during a CLEAR walk -> INIT restarts from set 0.
  - Counters = 0 afterwards.
